// File: rtl/lift_req_bank.sv
// Floor-request register bank: one request latch per floor, with position flags, a pending count
// and a registered next-target floor. Optional passenger cancel is enabled by LIFT_REQ_CANCEL_EN.
module lift_req_bank #(
   parameter int FLOORS = 4,
   parameter int FLW    = 2,
   parameter int CW     = 3
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              slowref,
   input  logic [FLOORS-1:0] pbpulse,
   input  logic              clr,
   input  logic [FLW-1:0]    clr_floor,
   input  logic [FLW-1:0]    cur_floor,
   input  logic              dir_up,
   output logic [FLOORS-1:0] req,
   output logic              req_here,
   output logic              req_above,
   output logic              req_below,
   output logic [CW-1:0]     req_count,
   output logic [FLW-1:0]    target,
   output logic              target_vld
);

   logic [FLOORS-1:0] next_req;
   logic [CW-1:0]     next_count;
   logic [FLW-1:0]    next_target;
   logic              next_vld;
   logic [FLW-1:0]    above_idx;
   logic [FLW-1:0]    below_idx;
   logic              in_range;

   assign in_range = (int'(cur_floor) < FLOORS);

   // A clear on the same floor always beats a press; the count follows the new latch value.
   always_comb begin
      next_req   = req;
      next_count = '0;
      for (int i = 0; i < FLOORS; i++) begin
         if (clr && (clr_floor == FLW'(i))) begin
            next_req[i] = 1'b0;
         end else if (pbpulse[i]) begin
`ifdef LIFT_REQ_CANCEL_EN
            next_req[i] = ~req[i];
`else
            next_req[i] = 1'b1;
`endif
         end
      end
      for (int i = 0; i < FLOORS; i++) begin
         next_count = next_count + CW'(next_req[i]);
      end
   end

   // Downward scan leaves the lowest floor above; upward scan leaves the highest floor below.
   always_comb begin
      req_here  = 1'b0;
      req_above = 1'b0;
      req_below = 1'b0;
      above_idx = '0;
      below_idx = '0;
      for (int j = FLOORS - 1; j >= 0; j--) begin
         if (req[j] && (j > int'(cur_floor))) begin
            req_above = 1'b1;
            above_idx = FLW'(j);
         end
         if (req[j] && (j == int'(cur_floor))) begin
            req_here = 1'b1;
         end
      end
      for (int j = 0; j < FLOORS; j++) begin
         if (req[j] && (j < int'(cur_floor))) begin
            req_below = 1'b1;
            below_idx = FLW'(j);
         end
      end
      if (!in_range) begin
         req_here  = 1'b0;
         req_above = 1'b0;
         req_below = 1'b0;
      end
   end

   always_comb begin
      next_target = target;
      next_vld    = 1'b0;
      if (in_range && (|req)) begin
         next_vld = 1'b1;
         if (req_here) begin
            next_target = cur_floor;
         end else if (dir_up) begin
            next_target = req_above ? above_idx : below_idx;
         end else begin
            next_target = req_below ? below_idx : above_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resetb) begin
         req        <= '0;
         req_count  <= '0;
         target     <= '0;
         target_vld <= 1'b0;
      end else if (slowref) begin
         req        <= next_req;
         req_count  <= next_count;
         target     <= next_target;
         target_vld <= next_vld;
      end
   end

endmodule

// File: tb/tb_lift_req_bank.sv
// Scoreboard bench for lift_req_bank: a behavioural model pushes expected state per cycle,
// compared one step after each clock edge. Honours LIFT_REQ_CANCEL_EN like the design.
module tb_lift_req_bank;
   localparam int FLOORS = 4;
   localparam int FLW    = 2;
   localparam int CW     = 3;

   logic              clk = 1'b0;
   logic              resetb = 1'b1;
   logic              slowref = 1'b0;
   logic [FLOORS-1:0] pbpulse = '0;
   logic              clr = 1'b0;
   logic [FLW-1:0]    clr_floor = '0;
   logic [FLW-1:0]    cur_floor = '0;
   logic              dir_up = 1'b0;
   logic [FLOORS-1:0] req;
   logic              req_here, req_above, req_below;
   logic [CW-1:0]     req_count;
   logic [FLW-1:0]    target;
   logic              target_vld;

   typedef struct {
      logic [FLOORS-1:0] req;
      logic [CW-1:0]     count;
      logic [FLW-1:0]    target;
      logic              vld;
      logic              here;
      logic              above;
      logic              below;
   } exp_t;

   exp_t sb[$];
   logic [FLOORS-1:0] m_req = '0;
   logic [FLW-1:0]    m_target = '0;
   logic              m_vld = 1'b0;
   int checks = 0;
   int fails = 0;

   lift_req_bank #(.FLOORS(FLOORS), .FLW(FLW), .CW(CW)) dut (
      .clk(clk), .resetb(resetb), .slowref(slowref), .pbpulse(pbpulse),
      .clr(clr), .clr_floor(clr_floor), .cur_floor(cur_floor), .dir_up(dir_up),
      .req(req), .req_here(req_here), .req_above(req_above), .req_below(req_below),
      .req_count(req_count), .target(target), .target_vld(target_vld)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Search outward from the current floor, preferring the travel direction.
   task automatic modelTarget(input logic [FLOORS-1:0] r, input int cur, input logic dir,
                              inout logic [FLW-1:0] t, output logic v);
      int up_hit, dn_hit;
      up_hit = -1;
      dn_hit = -1;
      v = 1'b0;
      if (cur < FLOORS && r != '0) begin
         v = 1'b1;
         for (int d = FLOORS - 1; d >= 1; d--) begin
            if (cur + d < FLOORS && r[cur + d]) up_hit = cur + d;
            if (cur - d >= 0 && r[cur - d]) dn_hit = cur - d;
         end
         if (r[cur]) t = FLW'(cur);
         else if (dir) t = (up_hit >= 0) ? FLW'(up_hit) : FLW'(dn_hit);
         else t = (dn_hit >= 0) ? FLW'(dn_hit) : FLW'(up_hit);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic tick, input logic [FLOORS-1:0] pb,
                                input logic c, input logic [FLW-1:0] cf,
                                input logic [FLW-1:0] cur, input logic dir);
      exp_t e;
      exp_t got;
      logic [FLOORS-1:0] nr;
      int ci;
      resetb = rst; slowref = tick; pbpulse = pb; clr = c; clr_floor = cf;
      cur_floor = cur; dir_up = dir;
      ci = int'(cur);
      nr = m_req;
      e.target = m_target;
      e.vld = m_vld;
      if (rst) begin
         nr = '0; e.target = '0; e.vld = 1'b0;
      end else if (tick) begin
         for (int i = 0; i < FLOORS; i++) begin
            if (c && int'(cf) == i) nr[i] = 1'b0;
`ifdef LIFT_REQ_CANCEL_EN
            else if (pb[i]) nr[i] = !m_req[i];
`else
            else if (pb[i]) nr[i] = 1'b1;
`endif
         end
         modelTarget(m_req, ci, dir, e.target, e.vld);
      end
      e.req = nr;
      e.count = CW'($countones(nr));
      e.here = 1'b0; e.above = 1'b0; e.below = 1'b0;
      for (int j = 0; j < FLOORS; j++) begin
         if (nr[j] && ci < FLOORS) begin
            if (j == ci) e.here = 1'b1;
            if (j > ci) e.above = 1'b1;
            if (j < ci) e.below = 1'b1;
         end
      end
      sb.push_back(e);
      m_req = nr; m_target = e.target; m_vld = e.vld;
      @(posedge clk);
      #1;
      got = sb.pop_front();
      checkOutput("req", 32'(req), 32'(got.req));
      checkOutput("req_count", 32'(req_count), 32'(got.count));
      checkOutput("target_vld", 32'(target_vld), 32'(got.vld));
      checkOutput("target", 32'(target), 32'(got.target));
      checkOutput("req_here", 32'(req_here), 32'(got.here));
      checkOutput("req_above", 32'(req_above), 32'(got.above));
      checkOutput("req_below", 32'(req_below), 32'(got.below));
   endtask

   initial begin
      // Reset, then lamp floors 0 and 2 and resolve a target going up from floor 1.
      applyStimulus(1, 0, 4'b0000, 0, 0, 1, 1);
      applyStimulus(0, 1, 4'b0101, 0, 0, 1, 1);
      checkOutput("plan_req_0101", 32'(req), 32'h5);
      applyStimulus(0, 1, 4'b0000, 0, 0, 1, 1);
      checkOutput("plan_target_2", 32'(target), 32'h2);
      // Presses away from a tick are lost.
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 4'b1000, 0, 0, 1, 1);
      // Leave only floor 2, then clear-beats-set on floor 2 while the target holds.
      applyStimulus(0, 1, 4'b0000, 1, 0, 1, 1);
      applyStimulus(0, 1, 4'b0100, 1, 2, 1, 1);
      checkOutput("plan_clear_wins", 32'(req), 32'h0);
      applyStimulus(0, 1, 4'b0000, 0, 0, 1, 1);
      applyStimulus(0, 1, 4'b0000, 0, 0, 1, 1);
      // Floors 0 and 3 seen from floor 2, both directions.
      applyStimulus(0, 1, 4'b1001, 0, 0, 2, 0);
      applyStimulus(0, 1, 4'b0000, 0, 0, 2, 0);
      checkOutput("plan_target_down", 32'(target), 32'h0);
      applyStimulus(0, 1, 4'b0000, 0, 0, 2, 1);
      checkOutput("plan_target_up", 32'(target), 32'h3);
      // Set with clear on another floor in the same tick.
      applyStimulus(0, 1, 4'b0110, 1, 3, 2, 1);
      // Repeat press on a lit floor (cancel or hold, depending on build).
      applyStimulus(1, 0, 4'b0000, 0, 0, 0, 0);
      applyStimulus(0, 1, 4'b0010, 0, 0, 0, 0);
      applyStimulus(0, 1, 4'b0010, 0, 0, 0, 0);
      // Reset wins over a full bank with slowref low.
      applyStimulus(0, 1, 4'b1111, 0, 0, 1, 1);
      applyStimulus(0, 1, 4'b0000, 0, 0, 1, 1);
      applyStimulus(1, 0, 4'b0000, 0, 0, 1, 1);
      checkOutput("plan_reset_mid", 32'(req), 32'h0);
      // Random traffic.
      for (int k = 0; k < 200; k++) begin
         applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                       FLOORS'($urandom_range(0, 15) & $urandom_range(0, 15)),
                       $urandom_range(0, 1) == 1, FLW'($urandom_range(0, 3)),
                       FLW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/lift_req_bank.md
Name: lift_req_bank

Overview:
- Parametrised floor-request register bank for the lift; the multi-floor successor to the per-floor top/ground request latch.
- Holds one request latch per floor, driven by debounced push-button pulses and cleared by the lift on arrival.
- Drives the floor LEDs and publishes above/below/here flags, a pending-request count and a registered next-target floor for the lift state machine.
- All state advances only on slowref ticks.

Parameters:
- FLOORS, 4, number of floors and request latches; legal range 2..16.
- FLW, 2, floor-index width; must satisfy 2**FLW >= FLOORS.
- CW, 3, pending-count width; must satisfy 2**CW > FLOORS.

Ports:
- clk  in  1  system clock.
- resetb  in  1  synchronous reset, active-high (1 = reset), sampled on posedge clk.
- slowref  in  1  one-clk tick enable; all state updates only when slowref=1.
- pbpulse  in  FLOORS  debounced button pulses, bit i = floor i.
- clr  in  1  clear strobe from the lift (arrived at clr_floor).
- clr_floor  in  FLW  floor index cleared when clr=1.
- cur_floor  in  FLW  lift's current floor.
- dir_up  in  1  lift travel direction: 1 = up, 0 = down.
- req  out  FLOORS  request latches; drive the floor LEDs.
- req_here  out  1  req[cur_floor].
- req_above  out  1  any req[j] with j > cur_floor.
- req_below  out  1  any req[j] with j < cur_floor.
- req_count  out  CW  number of set req bits.
- target  out  FLW  next floor for the lift.
- target_vld  out  1  target is meaningful.

Behaviour:
- Reset (resetb=1 at posedge clk): req=0, req_count=0, target=0, target_vld=0. Reset overrides slowref and wins mid-operation; no partial update.
- slowref=0: all registers hold. pbpulse and clr are ignored; pulses not aligned to a tick are lost by design.
- Per-floor latch i on a tick, in priority order:
  - clr=1 and clr_floor==i: req[i] becomes 0.
  - else pbpulse[i]=1: req[i] becomes 1.
  - else req[i] holds.
  - Clear beats set for the same floor in the same tick. A set on a different floor in the same tick is still taken.
- Pressing an already-lit floor: no effect (stays 1).
- clr_floor >= FLOORS: clear ignored.
- req_count is a registered count. Updated on the same tick edge as req and always equals popcount(req). Never wraps; max value is FLOORS.
- req_here, req_above, req_below are combinational from registered req and cur_floor. If cur_floor >= FLOORS, all three are 0.
- target and target_vld are registered. Updated on each tick from the pre-tick req value and current cur_floor/dir_up, so there is one tick of latency after a req change. Selection order:
  1. req[cur_floor] set: target=cur_floor.
  2. dir_up=1: lowest set floor above cur_floor; else highest set floor below.
  3. dir_up=0: highest set floor below cur_floor; else lowest set floor above.
  4. No req set, or cur_floor out of range: target_vld=0 and target holds its last value.
- Any resolved case sets target_vld=1.
- No X propagation: every next-state path is defined.

Optional Feature:
- Macro: LIFT_REQ_CANCEL_EN.
- Defined: a pbpulse on a floor whose req is already 1, with no clear on that floor, toggles that req to 0 (passenger cancel). req_count decrements accordingly. Clear still beats pulse.
- Undefined: a repeat press is ignored, as described in Behaviour.

Test Plan (FLOORS=4 unless noted):
- Reset then pbpulse=4'b0101 on a tick -> req=0101, req_count=2. On the next tick with cur_floor=1, dir_up=1: target=2, target_vld=1.
- pbpulse=4'b1000 with slowref=0 for 3 clks -> req unchanged, req_count unchanged.
- req=0100, on one tick clr=1, clr_floor=2 and pbpulse=4'b0100 -> req=0000, req_count=0; one tick later target_vld=0 and target holds its last value.
- req=1001, cur_floor=2, dir_up=0 -> req_above=1, req_below=1, req_here=0; next tick target=0. Flip dir_up=1 -> next tick target=3.
- resetb=1 asserted mid-sequence with req=1111, slowref=0 -> next clk req=0, req_count=0, target_vld=0.
- LIFT_REQ_CANCEL_EN defined, req=0010, pbpulse=4'b0010 on a tick -> req=0000, req_count=0. Without the macro -> req=0010.
